// File: rtl/cam_frame_capture_if.sv
// Camera pad bundle plus frame-buffer write port.
// master = camera/buffer side, slave = capture core.
interface cam_frame_capture_if #(
  parameter int ADDR_W = 15
);
  logic [7:0]        cam_dat;
  logic              cam_href;
  logic              cam_vsync;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output cam_dat,
    output cam_href,
    output cam_vsync,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  cam_dat,
    input  cam_href,
    input  cam_vsync,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/cam_frame_capture.sv
// Single-frame RGB565 capture from an 8-bit camera bus.
// Pads are registered; all framing decisions use the registered copies.
module cam_frame_capture #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  cam_frame_capture_if.slave bus,
  output logic              busy,
  output logic              done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(IMG_W + 1);
  localparam int RW   = $clog2(IMG_H + 1);
  localparam int BW   = $clog2(NPIX + 1);

  localparam logic [CW-1:0] COL_END = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H);
  localparam logic [BW-1:0] LN_STEP = BW'(IMG_W);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_SOF,
    CAPTURE
  } state_t;

  state_t state_q;

  logic [7:0] dat_q;
  logic       href_q;
  logic       href_prev_q;
  logic       vs_q;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] base_q, base_d;
  logic          phase_q, phase_d;
  logic [7:0]    hold_q, hold_d;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              wr_d;

  logic busy_q;
  logic done_q;

  logic href_fall;
  logic in_win;

  assign href_fall = href_prev_q & ~href_q;
  assign in_win    = (col_q < COL_END) &&
                     (row_q < ROW_END);

  // Byte pairing and line stepping; only applied while in CAPTURE.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    wr_d      = 1'b0;
    wr_data_d = {hold_q, dat_q};
    wr_addr_d = ADDR_W'(base_q + BW'(col_q));
    if (href_q) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hold_d = dat_q;
      end else begin
        wr_d = in_win;
        if (col_q < COL_END) begin
          col_d = col_q + 1'b1;
        end
      end
    end else if (href_fall) begin
      col_d   = '0;
      phase_d = 1'b0;
      if (row_q < ROW_END) begin
        row_d  = row_q + 1'b1;
        base_d = base_q + LN_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dat_q       <= '0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      vs_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      base_q      <= '0;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      dat_q       <= bus.cam_dat;
      href_q      <= bus.cam_href;
      href_prev_q <= href_q;
      vs_q        <= bus.cam_vsync;
      wr_en_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ARM: begin
          if (vs_q) begin
            state_q <= WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (!vs_q) begin
            state_q <= CAPTURE;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            phase_q <= 1'b0;
          end
        end
        CAPTURE: begin
          col_q   <= col_d;
          row_q   <= row_d;
          base_q  <= base_d;
          phase_q <= phase_d;
          hold_q  <= hold_d;
          // A pixel completing alongside vsync still lands.
          if (wr_d) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
          end
          if (vs_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Randomised + directed bench for cam_frame_capture.
// Writes are logged and compared with a line/pixel model.
module tb_cam_frame_capture;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;

  cam_frame_capture_if #(.ADDR_W(AW)) bus ();

  cam_frame_capture #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_n = 0;
  int tot_n  = 0;

  logic [7:0]        lb[$];
  logic [AW+15:0]    exp_q[$];
  logic [AW+15:0]    log_q[$];

  always @(negedge clk) begin
    if (bus.wr_en) log_q.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic frame_begin();
    bus.cam_vsync = 1'b1;
    step(3);
    bus.cam_vsync = 1'b0;
    step(3);
  endtask

  task automatic frame_end();
    bus.cam_vsync = 1'b1;
    step(6);
  endtask

  task automatic fill_seq(input int n, input int b0);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(8'(b0 + i));
  endtask

  task automatic fill_rnd(input int n);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
  endtask

  // Drive lb as one line; model: pixel p of line ln lands at ln*W+p.
  task automatic send_line(input int ln, input int gap,
                           input bit vs_last, input bit expect_wr);
    for (int i = 0; i < lb.size(); i++) begin
      bus.cam_href = 1'b1;
      bus.cam_dat  = lb[i];
      if (vs_last && i == lb.size() - 1) bus.cam_vsync = 1'b1;
      step(1);
    end
    bus.cam_href = 1'b0;
    bus.cam_dat  = 8'h00;
    step(gap);
    if (expect_wr) begin
      for (int p = 0; p < lb.size() / 2; p++) begin
        if (p < W && ln < H)
          exp_q.push_back({AW'(ln * W + p), lb[2*p], lb[2*p+1]});
      end
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    log_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.cam_dat   = 8'h00;
    bus.cam_href  = 1'b0;
    bus.cam_vsync = 1'b1;
    step(3);
    tot_n++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== '0)
      $display("FAIL rst_wr got %b/%h/%h want 0/0/0",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    else pass_n++;
    tot_n++;
    if ({busy, done} !== 2'b00)
      $display("FAIL rst_flags got %b want 00", {busy, done});
    else pass_n++;
    reset = 1'b0;
    step(2);
    tot_n++;
    if ({busy, done} !== 2'b00)
      $display("FAIL idle_flags got %b want 00", {busy, done});
    else pass_n++;
  endtask

  task automatic test_full_frame();
    clear_logs();
    pulse_start();
    tot_n++;
    if ({busy, done} !== 2'b10)
      $display("FAIL start_flags got %b want 10", {busy, done});
    else pass_n++;
    frame_begin();
    fill_seq(8, 0);
    send_line(0, 2, 1'b0, 1'b1);
    fill_seq(8, 8);
    send_line(1, 2, 1'b0, 1'b1);
    frame_end();
    tot_n++;
    if (log_q.size() != 8)
      $display("FAIL full_cnt got %0d want 8", log_q.size());
    else pass_n++;
    foreach (exp_q[i]) begin
      tot_n++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
      else $display("FAIL full_wr%0d got %h want %h", i,
                    (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
    end
    if (log_q.size() == 8) begin
      tot_n++;
      if (log_q[0] !== {3'd0, 16'h0001})
        $display("FAIL full_a0 got %h want 00001", log_q[0]);
      else pass_n++;
      tot_n++;
      if (log_q[7] !== {3'd7, 16'h0E0F})
        $display("FAIL full_a7 got %h want 70e0f", log_q[7]);
      else pass_n++;
    end
    tot_n++;
    if ({busy, done} !== 2'b01)
      $display("FAIL full_flags got %b want 01", {busy, done});
    else pass_n++;
  endtask

  task automatic test_midframe_start();
    clear_logs();
    bus.cam_vsync = 1'b0;
    step(2);
    fill_seq(8, 8'h40);
    for (int i = 0; i < 8; i++) begin
      bus.cam_href = 1'b1;
      bus.cam_dat  = lb[i];
      start = (i == 3);
      step(1);
    end
    start = 1'b0;
    bus.cam_href = 1'b0;
    step(2);
    fill_rnd(8);
    send_line(1, 2, 1'b0, 1'b0);
    tot_n++;
    if (log_q.size() != 0)
      $display("FAIL mid_early got %0d want 0", log_q.size());
    else pass_n++;
    tot_n++;
    if (busy !== 1'b1)
      $display("FAIL mid_busy got %b want 1", busy);
    else pass_n++;
    frame_begin();
    fill_rnd(8);
    send_line(0, 2, 1'b0, 1'b1);
    fill_rnd(8);
    send_line(1, 2, 1'b0, 1'b1);
    frame_end();
    tot_n++;
    if (log_q.size() != exp_q.size())
      $display("FAIL mid_cnt got %0d want %0d", log_q.size(), exp_q.size());
    else pass_n++;
    foreach (exp_q[i]) begin
      tot_n++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
      else $display("FAIL mid_wr%0d got %h want %h", i,
                    (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_long_short();
    clear_logs();
    pulse_start();
    frame_begin();
    fill_rnd(12);
    send_line(0, 3, 1'b0, 1'b1);
    fill_rnd(4);
    send_line(1, 3, 1'b0, 1'b1);
    frame_end();
    tot_n++;
    if (log_q.size() != 6)
      $display("FAIL ls_cnt got %0d want 6", log_q.size());
    else pass_n++;
    foreach (exp_q[i]) begin
      tot_n++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
      else $display("FAIL ls_wr%0d got %h want %h", i,
                    (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_odd_bytes();
    clear_logs();
    pulse_start();
    frame_begin();
    fill_seq(7, 8'hA0);
    send_line(0, 1, 1'b0, 1'b1);
    fill_seq(8, 8'hB0);
    send_line(1, 2, 1'b0, 1'b1);
    frame_end();
    tot_n++;
    if (log_q.size() != 7)
      $display("FAIL odd_cnt got %0d want 7", log_q.size());
    else pass_n++;
    foreach (exp_q[i]) begin
      tot_n++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
      else $display("FAIL odd_wr%0d got %h want %h", i,
                    (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_vsync_tail();
    clear_logs();
    pulse_start();
    frame_begin();
    fill_rnd(8);
    send_line(0, 2, 1'b0, 1'b1);
    fill_rnd(6);
    send_line(1, 2, 1'b1, 1'b1);
    step(4);
    tot_n++;
    if (log_q.size() != 7)
      $display("FAIL tail_cnt got %0d want 7", log_q.size());
    else pass_n++;
    foreach (exp_q[i]) begin
      tot_n++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
      else $display("FAIL tail_wr%0d got %h want %h", i,
                    (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
    end
    tot_n++;
    if ({busy, done} !== 2'b01)
      $display("FAIL tail_flags got %b want 01", {busy, done});
    else pass_n++;
  endtask

  task automatic test_reset_restart();
    clear_logs();
    pulse_start();
    frame_begin();
    fill_seq(6, 8'h11);
    for (int i = 0; i < 6; i++) begin
      bus.cam_href = 1'b1;
      bus.cam_dat  = lb[i];
      step(1);
    end
    bus.cam_href = 1'b0;
    step(3);
    tot_n++;
    if (log_q.size() != 3)
      $display("FAIL rr_pre got %0d want 3", log_q.size());
    else pass_n++;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    tot_n++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, busy, done} !== '0)
      $display("FAIL rr_async got %b/%h/%h/%b/%b want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, busy, done);
    else pass_n++;
    step(2);
    reset = 1'b0;
    log_q.delete();
    fill_rnd(8);
    send_line(0, 2, 1'b0, 1'b0);
    frame_begin();
    fill_rnd(8);
    send_line(0, 2, 1'b0, 1'b0);
    frame_end();
    tot_n++;
    if (log_q.size() != 0)
      $display("FAIL rr_quiet got %0d want 0", log_q.size());
    else pass_n++;
    tot_n++;
    if ({busy, done} !== 2'b00)
      $display("FAIL rr_flags got %b want 00", {busy, done});
    else pass_n++;
    clear_logs();
    pulse_start();
    frame_begin();
    fill_rnd(8);
    send_line(0, 2, 1'b0, 1'b1);
    fill_rnd(8);
    send_line(1, 2, 1'b0, 1'b1);
    frame_end();
    tot_n++;
    if (log_q.size() != exp_q.size())
      $display("FAIL rr_cnt got %0d want %0d", log_q.size(), exp_q.size());
    else pass_n++;
    foreach (exp_q[i]) begin
      tot_n++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
      else $display("FAIL rr_wr%0d got %h want %h", i,
                    (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_start_ignored();
    clear_logs();
    pulse_start();
    frame_begin();
    fill_rnd(8);
    send_line(0, 2, 1'b0, 1'b1);
    pulse_start();
    step(1);
    tot_n++;
    if ({busy, done} !== 2'b10)
      $display("FAIL ign_flags got %b want 10", {busy, done});
    else pass_n++;
    fill_rnd(8);
    send_line(1, 2, 1'b0, 1'b1);
    fill_rnd(8);
    send_line(2, 2, 1'b0, 1'b1);
    frame_end();
    tot_n++;
    if (log_q.size() != 8)
      $display("FAIL ign_cnt got %0d want 8", log_q.size());
    else pass_n++;
    foreach (exp_q[i]) begin
      tot_n++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
      else $display("FAIL ign_wr%0d got %h want %h", i,
                    (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
    end
    tot_n++;
    if (done !== 1'b1)
      $display("FAIL ign_done got %b want 1", done);
    else pass_n++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int nl;
      clear_logs();
      pulse_start();
      frame_begin();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        fill_rnd($urandom_range(1, 12));
        send_line(l, $urandom_range(1, 3), 1'b0, 1'b1);
      end
      frame_end();
      tot_n++;
      if (log_q.size() != exp_q.size())
        $display("FAIL rnd%0d_cnt got %0d want %0d",
                 f, log_q.size(), exp_q.size());
      else pass_n++;
      foreach (exp_q[i]) begin
        tot_n++;
        if (i < log_q.size() && log_q[i] === exp_q[i]) pass_n++;
        else $display("FAIL rnd%0d_wr%0d got %h want %h", f, i,
                      (i < log_q.size()) ? log_q[i] : 'x, exp_q[i]);
      end
      tot_n++;
      if ({busy, done} !== 2'b01)
        $display("FAIL rnd%0d_flags got %b want 01", f, {busy, done});
      else pass_n++;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_midframe_start();
    test_long_short();
    test_odd_bytes();
    test_vsync_tail();
    test_reset_restart();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
